// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
//   Transmit ownership arbiter for a radio front end. Three requesters
//   (ATU tune, CW keyer, host PTT) compete for the transmitter. The FSM
//   sequences the PA/TR relay (pa_on) ahead of RF drive (rf_en) through a
//   settle interval. It also holds the relay through a CW hang interval so
//   that keying between characters does not chatter the relay.
//
//   Optional build macro: TX_TIMEOUT_EN
//     Defined   -> transmit time-out counter plus a LOCKOUT state that forces
//                  everything off until all requests are released.
//     Undefined -> no counter, no LOCKOUT, the tot field is ignored and
//                  timeout_flag is tied low.
// -----------------------------------------------------------------------------
module tx_arbiter #(
    parameter logic [11:0] HANG_RST   = 12'd10,
    parameter logic [4:0]  SETTLE_RST = 5'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_rqst,
    input  logic        millisec_pulse,
    input  logic        tune_req,
    input  logic        cw_req,
    input  logic        host_req,
    input  logic        inhibit,
    output logic        pa_on,
    output logic        rf_en,
    output logic [2:0]  grant,
    output logic        timeout_flag
);

    localparam logic [5:0] CFG_ADDR = 6'h11;

    // One-hot owner codes, bit order {tune, cw, host}
    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_TUNE = 3'b100;
    localparam logic [2:0] G_CW   = 3'b010;
    localparam logic [2:0] G_HOST = 3'b001;

`ifdef TX_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_ACTIVE  = 3'd2,
        S_HANG    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_ACTIVE  = 3'd2,
        S_HANG    = 3'd3
    } state_t;
`endif

    // Configuration registers
    logic [11:0] r_hang_ms;
    logic [4:0]  r_settle_ms;
    logic        r_cw_pri;

    // FSM state, shared ms timer and registered outputs
    state_t      r_state;
    logic [11:0] r_timer;
    logic        r_pa_on;
    logic        r_rf_en;
    logic [2:0]  r_grant;

    // Combinational helpers
    logic [2:0]  w_pick;
    logic [2:0]  w_req_vec;
    logic        w_winner_held;
    logic        w_tune_preempt;
    logic        w_cfg_wr;

    assign w_cfg_wr       = cmd_rqst && (cmd_addr == CFG_ADDR);
    assign w_req_vec      = {tune_req, cw_req, host_req};
    // r_grant always holds the current winner while the transmitter is owned
    assign w_winner_held  = |(r_grant & w_req_vec);
    assign w_tune_preempt = tune_req && (r_grant != G_TUNE);

`ifdef TX_TIMEOUT_EN
    logic [3:0]  r_tot;
    logic [15:0] r_tx_ms;
    logic        r_timeout_flag;
    logic        w_tot_hit;
    logic        w_unused;

    assign w_tot_hit = (r_tot != 4'd0) && (r_tx_ms == {r_tot, 12'h000});
    assign w_unused  = &{1'b0, cmd_data[27:25], cmd_data[23:21], cmd_data[15:12]};
`else
    logic        w_unused;

    assign w_unused  = &{1'b0, cmd_data[31:25], cmd_data[23:21], cmd_data[15:12]};
`endif

    // Configuration register file written through the command bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hang_ms   <= HANG_RST;
            r_settle_ms <= SETTLE_RST;
            r_cw_pri    <= 1'b0;
`ifdef TX_TIMEOUT_EN
            r_tot       <= 4'd0;
`endif
        end else if (w_cfg_wr) begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_hang_ms   <= cmd_data[11:0];
            r_settle_ms <= cmd_data[20:16];
            r_cw_pri    <= cmd_data[24];
`ifdef TX_TIMEOUT_EN
            r_tot       <= cmd_data[31:28];
`endif
        end
    end

    // Fixed-priority pick: tune first, then cw/host order chosen by cw_pri
    always_comb begin
        // NOTE: default first so no path leaves w_pick unassigned (no latch).
        w_pick = G_NONE;
        if (tune_req) begin
            w_pick = G_TUNE;
        end else if (r_cw_pri) begin
            if (cw_req)        w_pick = G_CW;
            else if (host_req) w_pick = G_HOST;
        end else begin
            if (host_req)      w_pick = G_HOST;
            else if (cw_req)   w_pick = G_CW;
        end
    end

`ifdef TX_TIMEOUT_EN
    // Key-down time accumulator: counts ms while the relay is driven,
    // cleared whenever the arbiter is idle, saturating at full scale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_ms <= 16'd0;
        end else if (r_state == S_IDLE) begin
            r_tx_ms <= 16'd0;
        end else if (r_pa_on && millisec_pulse && (r_tx_ms != 16'hFFFF)) begin
            r_tx_ms <= r_tx_ms + 16'd1;
        end
    end
`endif

    // Transmit sequencing FSM with registered relay/drive/grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_timer        <= 12'd0;
            r_pa_on        <= 1'b0;
            r_rf_en        <= 1'b0;
            r_grant        <= G_NONE;
`ifdef TX_TIMEOUT_EN
            r_timeout_flag <= 1'b0;
`endif
        end else begin
            // Timer counts milliseconds down to zero; loads below override
            if (millisec_pulse && (r_timer != 12'd0)) begin
                r_timer <= r_timer - 12'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if ((w_pick != G_NONE) && !inhibit) begin
                        r_state <= S_SETTLE;
                        r_grant <= w_pick;
                        r_timer <= {7'd0, r_settle_ms};
                        r_pa_on <= 1'b1;
                        r_rf_en <= 1'b0;
                    end
                end

                S_SETTLE, S_ACTIVE, S_HANG: begin
                    if (inhibit) begin
                        r_state <= S_IDLE;
                        r_pa_on <= 1'b0;
                        r_rf_en <= 1'b0;
                        r_grant <= G_NONE;
`ifdef TX_TIMEOUT_EN
                    end else if (w_tot_hit) begin
                        r_state        <= S_LOCKOUT;
                        r_pa_on        <= 1'b0;
                        r_rf_en        <= 1'b0;
                        r_grant        <= G_NONE;
                        r_timeout_flag <= 1'b1;
`endif
                    end else if (w_tune_preempt) begin
                        // Tune steals ownership; the relay stays closed while
                        // the new settle interval runs
                        r_state <= S_SETTLE;
                        r_grant <= G_TUNE;
                        r_timer <= {7'd0, r_settle_ms};
                        r_pa_on <= 1'b1;
                        r_rf_en <= 1'b0;
                    end else if (r_state == S_SETTLE) begin
                        if (!w_winner_held) begin
                            r_state <= S_IDLE;
                            r_pa_on <= 1'b0;
                            r_rf_en <= 1'b0;
                            r_grant <= G_NONE;
                        end else if (r_timer == 12'd0) begin
                            r_state <= S_ACTIVE;
                            r_rf_en <= 1'b1;
                        end
                    end else if (r_state == S_ACTIVE) begin
                        if (!w_winner_held) begin
                            if ((r_grant == G_CW) && (r_hang_ms != 12'd0)) begin
                                r_state <= S_HANG;
                                r_timer <= r_hang_ms;
                                r_rf_en <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_pa_on <= 1'b0;
                                r_rf_en <= 1'b0;
                                r_grant <= G_NONE;
                            end
                        end
                    end else begin
                        // HANG: only a CW re-key resumes; host cannot preempt
                        if (cw_req) begin
                            r_state <= S_ACTIVE;
                            r_rf_en <= 1'b1;
                        end else if (r_timer == 12'd0) begin
                            r_state <= S_IDLE;
                            r_pa_on <= 1'b0;
                            r_rf_en <= 1'b0;
                            r_grant <= G_NONE;
                        end
                    end
                end

`ifdef TX_TIMEOUT_EN
                S_LOCKOUT: begin
                    if (w_req_vec == 3'b000) begin
                        r_state        <= S_IDLE;
                        r_timeout_flag <= 1'b0;
                    end
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                    r_pa_on <= 1'b0;
                    r_rf_en <= 1'b0;
                    r_grant <= G_NONE;
                end
            endcase
        end
    end

    // rf_en is gated by inhibit without waiting for a clock edge
    assign rf_en = r_rf_en & ~inhibit;
    assign pa_on = r_pa_on;
    assign grant = r_grant;

`ifdef TX_TIMEOUT_EN
    assign timeout_flag = r_timeout_flag;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
//   Directed bench for tx_arbiter: a table of single-cycle vectors followed by
//   hand-written multi-cycle sequences (CW hang, tune preemption, inhibit,
//   reset mid-transmission, transmit time-out).
// -----------------------------------------------------------------------------
module tb_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        millisec_pulse;
    logic        tune_req;
    logic        cw_req;
    logic        host_req;
    logic        inhibit;
    logic        pa_on;
    logic        rf_en;
    logic [2:0]  grant;
    logic        timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    tx_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .cmd_rqst       (cmd_rqst),
        .millisec_pulse (millisec_pulse),
        .tune_req       (tune_req),
        .cw_req         (cw_req),
        .host_req       (host_req),
        .inhibit        (inhibit),
        .pa_on          (pa_on),
        .rf_en          (rf_en),
        .grant          (grant),
        .timeout_flag   (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs for one clock, outputs expected after that edge
    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        tune;
        logic        cw;
        logic        host;
        logic        inh;
        logic        ms;
        logic        exp_pa;
        logic        exp_rf;
        logic [2:0]  exp_g;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic wr, input logic [31:0] data,
                                input logic tune, input logic cw, input logic host,
                                input logic inh, input logic ms,
                                input logic exp_pa, input logic exp_rf,
                                input logic [2:0] exp_g);
        vec_t v;
        v.wr = wr; v.data = data; v.tune = tune; v.cw = cw; v.host = host;
        v.inh = inh; v.ms = ms; v.exp_pa = exp_pa; v.exp_rf = exp_rf; v.exp_g = exp_g;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled at negedge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ms(input int n);
        for (int k = 0; k < n; k++) begin
            millisec_pulse = 1'b1;
            @(negedge clk);
            millisec_pulse = 1'b0;
        end
    endtask

    task automatic cfg_write(input logic [31:0] data);
        cmd_addr = 6'h11;
        cmd_data = data;
        cmd_rqst = 1'b1;
        @(negedge clk);
        cmd_rqst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic pa_dropped;

        rst_n = 1'b0; cmd_addr = 6'h00; cmd_data = 32'h0; cmd_rqst = 1'b0;
        millisec_pulse = 1'b0; tune_req = 1'b0; cw_req = 1'b0;
        host_req = 1'b0; inhibit = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("reset pa_on", pa_on, 1'b0);
        check("reset rf_en", rf_en, 1'b0);
        check("reset grant", grant, 3'b000);
        check("reset timeout_flag", timeout_flag, 1'b0);
        rst_n = 1'b1;
        tick();

        // ---------------- vector table ----------------
        //          wr  data          tn cw hs ih ms   pa rf grant
        tbl.push_back(mk(1, 32'h0005_0000, 0, 0, 0, 0, 0,  0, 0, 3'b000)); // settle=5 hang=0 cw_pri=0
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 0,  1, 0, 3'b001)); // host -> SETTLE
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 1,  1, 0, 3'b001)); // ms 1
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 1,  1, 0, 3'b001)); // ms 2
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 1,  1, 0, 3'b001)); // ms 3
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 1,  1, 0, 3'b001)); // ms 4
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 1,  1, 0, 3'b001)); // ms 5, timer 0
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 0,  1, 1, 3'b001)); // ACTIVE
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 0,  1, 1, 3'b001));
        tbl.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 3'b000)); // host drop -> IDLE
        tbl.push_back(mk(0, 32'h0,         0, 1, 1, 0, 0,  1, 0, 3'b001)); // tie, host wins
        tbl.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 3'b000)); // drop in SETTLE
        tbl.push_back(mk(1, 32'h0105_0000, 0, 0, 0, 0, 0,  0, 0, 3'b000)); // cw_pri=1
        tbl.push_back(mk(0, 32'h0,         0, 1, 1, 0, 0,  1, 0, 3'b010)); // tie, cw wins
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 0,  0, 0, 3'b000)); // cw drop -> IDLE
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 0,  1, 0, 3'b001)); // host alone
        tbl.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 3'b000));
        tbl.push_back(mk(1, 32'h0100_0000, 0, 0, 0, 0, 0,  0, 0, 3'b000)); // settle=0
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 0,  1, 0, 3'b001)); // SETTLE one clk
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 0,  1, 1, 3'b001)); // ACTIVE
        tbl.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 3'b000));
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 1, 0,  0, 0, 3'b000)); // inhibited in IDLE
        tbl.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 3'b000));
        tbl.push_back(mk(0, 32'h0,         0, 1, 0, 0, 0,  1, 0, 3'b010)); // cw SETTLE
        tbl.push_back(mk(0, 32'h0,         0, 1, 0, 0, 0,  1, 1, 3'b010)); // cw ACTIVE
        tbl.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 3'b000)); // hang=0 -> IDLE

        for (int i = 0; i < tbl.size(); i++) begin
            cmd_addr       = 6'h11;
            cmd_data       = tbl[i].data;
            cmd_rqst       = tbl[i].wr;
            tune_req       = tbl[i].tune;
            cw_req         = tbl[i].cw;
            host_req       = tbl[i].host;
            inhibit        = tbl[i].inh;
            millisec_pulse = tbl[i].ms;
            tick();
            check($sformatf("row%0d pa_on", i), pa_on, tbl[i].exp_pa);
            check($sformatf("row%0d rf_en", i), rf_en, tbl[i].exp_rf);
            check($sformatf("row%0d grant", i), grant, tbl[i].exp_g);
            check($sformatf("row%0d timeout_flag", i), timeout_flag, 1'b0);
        end
        cmd_rqst = 1'b0; tune_req = 1'b0; cw_req = 1'b0; host_req = 1'b0;
        inhibit = 1'b0; millisec_pulse = 1'b0;
        tick();

        // ---------------- CW hang and re-key ----------------
        cfg_write(32'h0000_0014);          // hang=20, settle=0, cw_pri=0
        cw_req = 1'b1;
        tick(); tick();
        check("cw active rf_en", rf_en, 1'b1);
        check("cw active grant", grant, 3'b010);
        ms(10);
        cw_req = 1'b0;
        tick();
        check("hang pa_on", pa_on, 1'b1);
        check("hang rf_en", rf_en, 1'b0);
        check("hang grant", grant, 3'b010);
        pa_dropped = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ms(1);
            if (pa_on !== 1'b1) pa_dropped = 1'b1;
        end
        cw_req = 1'b1;
        tick();
        if (pa_on !== 1'b1) pa_dropped = 1'b1;
        check("rekey rf_en", rf_en, 1'b1);
        check("rekey grant", grant, 3'b010);
        check("rekey pa_on never dropped", pa_dropped, 1'b0);
        cw_req = 1'b0;
        tick();
        host_req = 1'b1;                   // host must not preempt HANG
        ms(19);
        check("hang 19ms pa_on", pa_on, 1'b1);
        check("hang host ignored grant", grant, 3'b010);
        check("hang host ignored rf_en", rf_en, 1'b0);
        host_req = 1'b0;
        ms(1);
        tick();
        check("hang expiry pa_on", pa_on, 1'b0);
        check("hang expiry grant", grant, 3'b000);

        // ---------------- tune preemption and inhibit ----------------
        cfg_write(32'h0005_0000);          // settle=5, hang=0
        host_req = 1'b1;
        tick(); ms(5); tick();
        check("host active rf_en", rf_en, 1'b1);
        tune_req = 1'b1;
        tick();
        check("preempt grant", grant, 3'b100);
        check("preempt rf_en", rf_en, 1'b0);
        check("preempt pa_on", pa_on, 1'b1);
        ms(4);
        check("tune settle 4ms rf_en", rf_en, 1'b0);
        check("tune settle 4ms pa_on", pa_on, 1'b1);
        ms(1);
        check("tune settle 5ms rf_en", rf_en, 1'b0);
        tick();
        check("tune active rf_en", rf_en, 1'b1);
        check("tune active grant", grant, 3'b100);
        inhibit = 1'b1;
        #1;
        check("inhibit same-cycle rf_en", rf_en, 1'b0);
        check("inhibit same-cycle pa_on", pa_on, 1'b1);
        @(negedge clk);
        check("inhibit next clk pa_on", pa_on, 1'b0);
        check("inhibit next clk grant", grant, 3'b000);
        inhibit = 1'b0; tune_req = 1'b0; host_req = 1'b0;
        tick();

        // ---------------- reset mid-transmission ----------------
        cfg_write(32'h0000_0000);          // settle=0 so a reset reload is visible
        host_req = 1'b1;
        tick(); tick();
        check("pre-reset rf_en", rf_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset pa_on", pa_on, 1'b0);
        check("async reset rf_en", rf_en, 1'b0);
        check("async reset grant", grant, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post-reset settle pa_on", pa_on, 1'b1);
        ms(4);
        check("post-reset settle rf_en", rf_en, 1'b0);
        ms(1);
        tick();
        check("post-reset active rf_en", rf_en, 1'b1);
        host_req = 1'b0;
        tick();

        // ---------------- transmit time-out ----------------
        cfg_write(32'h1000_0000);          // tot=1, settle=0, hang=0
        host_req = 1'b1;
        tick(); tick();
`ifdef TX_TIMEOUT_EN
        ms(4095);
        check("tot 4095ms pa_on", pa_on, 1'b1);
        check("tot 4095ms flag", timeout_flag, 1'b0);
        ms(1);
        tick();
        check("lockout flag", timeout_flag, 1'b1);
        check("lockout pa_on", pa_on, 1'b0);
        check("lockout rf_en", rf_en, 1'b0);
        check("lockout grant", grant, 3'b000);
        tick(); tick();
        check("lockout held flag", timeout_flag, 1'b1);
        host_req = 1'b0;
        tick();
        check("lockout release flag", timeout_flag, 1'b0);
        check("lockout release pa_on", pa_on, 1'b0);
`else
        ms(4100);
        check("no timeout flag", timeout_flag, 1'b0);
        check("no timeout pa_on", pa_on, 1'b1);
        check("no timeout rf_en", rf_en, 1'b1);
        host_req = 1'b0;
        tick();
        check("no timeout release pa_on", pa_on, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter HANG_RST, 12'd10: hang_ms value loaded at reset.
REQ-002 Parameter SETTLE_RST, 5'd5: settle_ms value loaded at reset.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_addr  input  6  command bus address.
REQ-006 cmd_data  input  32  command bus data.
REQ-007 cmd_rqst  input  1  command bus write strobe, one clk wide.
REQ-008 millisec_pulse  input  1  one-clk pulse every 1 ms.
REQ-009 tune_req  input  1  ATU tune transmit request.
REQ-010 cw_req  input  1  CW keyer keydown request.
REQ-011 host_req  input  1  host PTT request.
REQ-012 inhibit  input  1  external TX inhibit.
REQ-013 pa_on  output  1  PA/TR relay drive.
REQ-014 rf_en  output  1  RF drive permitted.
REQ-015 grant  output  3  one-hot owner {tune,cw,host}; 3'b000 when no owner.
REQ-016 timeout_flag  output  1  TX timeout lockout active.

Function
REQ-017 On cmd_rqst with cmd_addr==6'h11, the block SHALL latch hang_ms=cmd_data[11:0], settle_ms=cmd_data[20:16], cw_pri=cmd_data[24] and tot=cmd_data[31:28]; new values take effect at the next timer load.
REQ-018 Priority SHALL be tune highest, then cw over host if cw_pri=1, else host over cw; simultaneous same-cycle requests resolve by this order.
REQ-019 12-bit timer SHALL decrement only on millisec_pulse and saturate at 0.
REQ-020 IDLE: pa_on=0, rf_en=0, grant=0; any request with inhibit=0 -> latch winner, load settle_ms, go SETTLE next clk.
REQ-021 SETTLE: pa_on=1, rf_en=0, grant=winner; timer==0 -> ACTIVE; settle_ms=0 exits SETTLE after one clk; winner request drop -> IDLE next clk.
REQ-022 ACTIVE: pa_on=1, rf_en=1, grant=winner; winner drop -> HANG with timer=hang_ms if winner is cw, else IDLE; hang_ms=0 -> IDLE directly.
REQ-023 tune_req while winner!=tune in SETTLE/ACTIVE/HANG SHALL switch winner to tune and reload settle_ms into SETTLE, keeping pa_on=1.
REQ-024 HANG: pa_on=1, rf_en=0, grant=cw; cw_req reassert -> ACTIVE next clk without settle; timer==0 -> IDLE; host_req alone does not preempt HANG.
REQ-025 inhibit=1 SHALL force rf_en=0 combinationally in the same cycle and move the FSM to IDLE on the next clk from any non-IDLE state.
REQ-026 rf_en SHALL never be 1 while pa_on=0, and grant SHALL always be one-hot or zero.

Reset
REQ-027 While rst_n=0: state=IDLE, timer=0, pa_on=0, rf_en=0, grant=0, timeout_flag=0, hang_ms=HANG_RST, settle_ms=SETTLE_RST, cw_pri=0, tot=0.
REQ-028 Reset assertion mid-transmission SHALL drop pa_on and rf_en immediately, independent of clk.

Configuration
REQ-029 Macro TX_TIMEOUT_EN defined: a 16-bit ms counter SHALL count while pa_on=1, clear in IDLE, and when tot!=0 and count=={tot,12'h000} enter LOCKOUT (all outputs 0 except timeout_flag=1) until all three requests are low, then IDLE with timeout_flag cleared.
REQ-030 Macro TX_TIMEOUT_EN undefined: no counter, no LOCKOUT state, tot ignored, timeout_flag tied 0.

Verification
REQ-031 Write 6'h11 with settle=5, hang=0; host_req high -> pa_on next clk, rf_en after 5 millisec_pulses, grant=3'b001; host_req low -> all outputs 0 next clk.
REQ-032 hang=20; cw_req 10 ms pulse, release, reassert after 8 ms -> rf_en back next clk, pa_on never drops; no reassert -> IDLE after 20 pulses.
REQ-033 host ACTIVE, tune_req rises -> grant=3'b100, rf_en=0 for 5 ms, pa_on stays 1.
REQ-034 host_req and cw_req same clk with cw_pri=0 then 1 -> grant 3'b001 then 3'b010; inhibit pulse during ACTIVE -> rf_en=0 same cycle, IDLE next clk.
REQ-035 TX_TIMEOUT_EN, tot=1, host_req held -> LOCKOUT after 4096 ms of pa_on, timeout_flag=1; release host_req -> flag clears; without macro flag stays 0.
